mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares the single data-memory/LSU port between the core's load/store path and an external debug/loader master. Each side presents one request at a time. The arbiter picks a winner, launches one access into a memory with fixed read latency, and waits out that latency. It returns read data with a one-cycle valid pulse and produces the stall the core needs while its access is outstanding. It sits between the control unit/ALU address path and the load-store unit.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles from the `o_mem_req` cycle to valid `i_mem_rdata`. Legal range 1..15.
- `STARVE_MAX`, default 8: number of consecutive contested arbitrations the core may win before the debug master is forced through. Legal range 1..255.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_core_req`, in, 1: core access request. Held, with its payload stable, until the matching `o_core_rvalid`.
- `i_core_we`, in, 1: core write enable.
- `i_core_addr`, in, 32: core address.
- `i_core_wdata`, in, 32: core store data.
- `i_core_bmask`, in, 4: core byte mask.
- `o_core_gnt`, out, 1: one-cycle pulse when the core request is accepted.
- `o_core_rvalid`, out, 1: one-cycle pulse marking completion of the core access.
- `o_core_rdata`, out, 32: core read data; valid with `o_core_rvalid`.
- `o_core_stall`, out, 1: equals `i_core_req & ~o_core_rvalid`.
- `i_dbg_req`, `i_dbg_we`, `i_dbg_addr`[32], `i_dbg_wdata`[32], `i_dbg_bmask`[4], in: debug-side request and payload, same rules as the core side.
- `o_dbg_gnt`, `o_dbg_rvalid`, out, 1 each: debug-side grant and completion pulses.
- `o_dbg_rdata`, out, 32: debug read data; valid with `o_dbg_rvalid`.
- `o_mem_req`, out, 1: one-cycle access strobe to memory.
- `o_mem_we`, `o_mem_addr`[32], `o_mem_wdata`[32], `o_mem_bmask`[4], out: registered payload, held stable from the `o_mem_req` cycle until the state returns to IDLE.
- `i_mem_rdata`, in, 32: memory read data, valid exactly `MEM_LAT` cycles after `o_mem_req`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, the winner gets a combinational `o_*_gnt` in the same cycle.
  - The winner's payload and identity are latched. Next state is ISSUE.
- ISSUE: `o_mem_req`=1 for exactly one cycle. A 4-bit latency counter is loaded with `MEM_LAT-1`. Next state is WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, `i_mem_rdata` is captured. Next state is RESP.
  - With `MEM_LAT`=1, WAIT lasts one cycle.
- RESP: the winner's `o_*_rvalid`=1 for one cycle. `o_*_rdata` holds the captured word for reads and 0 for writes. Next state is IDLE.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting: the core wins unless the starvation guard fires (see Configuration).
- Payload lines of the losing requester are ignored. The loser's request stays pending.
- Each rdata output holds its last value until the next rvalid on the same side.
- Addresses and byte masks pass through unmodified. Alignment checking is the LSU's job.

## Timing
- Request seen in IDLE at cycle 0: gnt at cycle 0, `o_mem_req` at cycle 1, rdata captured at the end of cycle `1+MEM_LAT`, rvalid at cycle `2+MEM_LAT`, IDLE at cycle `3+MEM_LAT`.
- Throughput: one access per `MEM_LAT+3` cycles. A request pending at the RESP→IDLE edge is granted in the first IDLE cycle.
- A held request is never granted twice. A new gnt is impossible outside IDLE.
- Reset values: state IDLE; all gnt, rvalid and `o_mem_req` 0; all rdata 0; `o_mem_*` payload 0; counters 0.
- Reset mid-access: the in-flight access is abandoned, no rvalid is produced, and the state is IDLE on the next cycle.
- A requester dropping req before its gnt: permitted, nothing is launched for it.
- A requester dropping req after its gnt: illegal, and behaviour is undefined.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - An 8-bit counter increments on every IDLE arbitration where both sides request and the core wins.
  - The counter clears whenever debug wins. It saturates at `STARVE_MAX`.
  - When the counter equals `STARVE_MAX` and both sides request, debug wins.
- `ARB_STARVE_GUARD_EN` undefined: strict core priority; no counter logic is present.

## Test plan
- Core read alone, `MEM_LAT`=1, address 0x0000_0010, memory returns 0xDEAD_BEEF → `o_core_gnt` at c0, `o_mem_req` at c1, `o_core_rvalid` with rdata 0xDEAD_BEEF at c3, `o_core_stall` high c0–c2 and low at c3.
- Debug write alone, `MEM_LAT`=3, addr 0x0000_0100, wdata 0x1234_5678, bmask 0xF → `o_mem_we`=1 with that payload from c1 to c5, `o_dbg_rvalid` at c5, `o_dbg_rdata`=0.
- Both requesting continuously, guard enabled, `STARVE_MAX`=2 → grant order core, core, dbg, core, core, dbg.
- Same stimulus with guard disabled → the core wins every arbitration and `o_dbg_gnt` is never asserted.
- `i_reset` pulsed during WAIT (`MEM_LAT`=4, at c3) → no rvalid on either side, all outputs at reset values, and the next request is granted normally after reset is released.
- Debug request raised during a core access → `o_dbg_gnt` in the first IDLE cycle after core RESP; no overlap of `o_mem_req` pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, debug and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
  logic        i_core_req;
  logic        i_core_we;
  logic [31:0] i_core_addr;
  logic [31:0] i_core_wdata;
  logic [3:0]  i_core_bmask;
  logic        o_core_gnt;
  logic        o_core_rvalid;
  logic [31:0] o_core_rdata;
  logic        o_core_stall;
  logic        i_dbg_req;
  logic        i_dbg_we;
  logic [31:0] i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic [3:0]  i_dbg_bmask;
  logic        o_dbg_gnt;
  logic        o_dbg_rvalid;
  logic [31:0] o_dbg_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_mem_rdata;
  modport slave (
    input  i_core_req, i_core_we, i_core_addr, i_core_wdata, i_core_bmask,
    output o_core_gnt, o_core_rvalid, o_core_rdata, o_core_stall,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_bmask,
    output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    input  i_mem_rdata
  );
  modport master (
    output i_core_req, i_core_we, i_core_addr, i_core_wdata, i_core_bmask,
    input  o_core_gnt, o_core_rvalid, o_core_rdata, o_core_stall,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_bmask,
    input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between core and debug masters; ARB_STARVE_GUARD_EN enables the debug starvation guard
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_lat;
  logic        r_sel_dbg, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_bmask;
  logic [31:0] r_core_rdata, r_dbg_rdata;
  logic        w_idle, w_pick_dbg, w_guard, w_done, w_core_gnt, w_dbg_gnt;
  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_param_chk
    $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
  end
  assign w_idle     = r_state == IDLE;
  assign w_done     = r_state == WAIT && r_lat == 4'd0;
  assign w_pick_dbg = bus.i_dbg_req & (~bus.i_core_req | w_guard);
`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] r_starve;
  // Count contested core wins, saturating; a debug win restarts the count
  always_ff @(posedge i_clk)
    if (i_reset) r_starve <= '0;
    else if (w_dbg_gnt) r_starve <= '0;
    else if (w_core_gnt && bus.i_dbg_req && r_starve != 8'(STARVE_MAX)) r_starve <= r_starve + 8'd1;
  assign w_guard = r_starve == 8'(STARVE_MAX);
`else
  assign w_guard = 1'b0;
`endif
  // State register
  always_ff @(posedge i_clk)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  // Next state and same-cycle grants; grants only ever come from IDLE
  always_comb begin
    w_next     = r_state;
    w_core_gnt = w_idle & bus.i_core_req & ~w_pick_dbg;
    w_dbg_gnt  = w_idle & w_pick_dbg;
    if (w_core_gnt || w_dbg_gnt) w_next = ISSUE;
    else if (r_state == ISSUE) w_next = WAIT;
    else if (w_done) w_next = RESP;
    else if (r_state == RESP) w_next = IDLE;
  end
  // Latch the winner's payload, run the latency counter and capture read data
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_sel_dbg    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bmask      <= '0;
      r_lat        <= '0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (w_core_gnt || w_dbg_gnt) begin
        r_sel_dbg <= w_dbg_gnt;
        r_we      <= w_dbg_gnt ? bus.i_dbg_we    : bus.i_core_we;
        r_addr    <= w_dbg_gnt ? bus.i_dbg_addr  : bus.i_core_addr;
        r_wdata   <= w_dbg_gnt ? bus.i_dbg_wdata : bus.i_core_wdata;
        r_bmask   <= w_dbg_gnt ? bus.i_dbg_bmask : bus.i_core_bmask;
      end
      if (r_state == ISSUE) r_lat <= 4'(MEM_LAT - 1);
      else if (r_state == WAIT && r_lat != 4'd0) r_lat <= r_lat - 4'd1;
      if (w_done && !r_sel_dbg) r_core_rdata <= r_we ? '0 : bus.i_mem_rdata;
      if (w_done && r_sel_dbg) r_dbg_rdata <= r_we ? '0 : bus.i_mem_rdata;
    end
  assign bus.o_core_gnt    = w_core_gnt;
  assign bus.o_dbg_gnt     = w_dbg_gnt;
  assign bus.o_core_rvalid = r_state == RESP && !r_sel_dbg;
  assign bus.o_dbg_rvalid  = r_state == RESP && r_sel_dbg;
  assign bus.o_core_rdata  = r_core_rdata;
  assign bus.o_dbg_rdata   = r_dbg_rdata;
  assign bus.o_core_stall  = bus.i_core_req & ~bus.o_core_rvalid;
  assign bus.o_mem_req     = r_state == ISSUE;
  assign bus.o_mem_we      = r_we;
  assign bus.o_mem_addr    = r_addr;
  assign bus.o_mem_wdata   = r_wdata;
  assign bus.o_mem_bmask   = r_bmask;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a fixed-latency memory model
module tb_mem_port_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 2;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bm;
    logic [31:0] rdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  txn_t core_q[$];
  txn_t dbg_q[$];
  bit ord_q[$];
  logic [31:0] mem [logic [31:0]];
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic drive(input bit side, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] bm, input logic [31:0] rd);
    int n;
    txn_t t = '{we, a, wd, bm, rd};
    if (side) dbg_q.push_back(t);
    else core_q.push_back(t);
    if (side) begin
      bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = a; bus.i_dbg_wdata = wd; bus.i_dbg_bmask = bm;
    end else begin
      bus.i_core_req = 1'b1; bus.i_core_we = we; bus.i_core_addr = a; bus.i_core_wdata = wd; bus.i_core_bmask = bm;
    end
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (side ? bus.o_dbg_rvalid : bus.o_core_rvalid) break;
    end
    if (n == 40) begin
      total++;
      bad++;
      $display("FAIL rvalid_timeout side=%0d got=none exp=rvalid", side);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic single(input bit side, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] bm, input logic [31:0] rd);
    ord_q.push_back(side);
    drive(side, we, a, wd, bm, rd);
    if (side) bus.i_dbg_req = 1'b0;
    else bus.i_core_req = 1'b0;
  endtask
  initial begin
    int due;
    logic [31:0] pend, w;
    due = -1;
    pend = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_rdata = (cyc == due) ? pend : (32'hBAD0_0000 ^ 32'(cyc));
      if (!rst && bus.o_mem_req) begin
        w = mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : 32'h0;
        if (bus.o_mem_we) begin
          for (int b = 0; b < 4; b++) if (bus.o_mem_bmask[b]) w[8*b+:8] = bus.o_mem_wdata[8*b+:8];
          mem[bus.o_mem_addr] = w;
        end else begin
          pend = w;
          due = cyc + LAT;
        end
      end
    end
  end
  initial begin
    bit busy, side, s, exp_rv, exp_mr;
    int g;
    txn_t cur;
    busy = 1'b0;
    side = 1'b0;
    g = 0;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        continue;
      end
      exp_mr = busy && cyc == g + 1;
      exp_rv = busy && cyc == g + LAT + 2;
      if (!busy && (bus.i_core_req || bus.i_dbg_req)) chk("gnt_in_idle", 64'(bus.o_core_gnt | bus.o_dbg_gnt), 1);
      if (bus.o_core_gnt || bus.o_dbg_gnt) begin
        chk("gnt_both", 64'(bus.o_core_gnt & bus.o_dbg_gnt), 0);
        chk("gnt_while_busy", 64'(busy), 0);
        s = bus.o_dbg_gnt;
        if (ord_q.size() == 0) chk("gnt_unexpected", 64'(s), 64'hFFFF);
        else chk("gnt_side", 64'(s), 64'(ord_q.pop_front()));
        if (s ? dbg_q.size() == 0 : core_q.size() == 0) chk("gnt_no_txn", 64'(s), 64'hFFFF);
        else cur = s ? dbg_q.pop_front() : core_q.pop_front();
        side = s;
        busy = 1'b1;
        g = cyc;
      end
      if (bus.o_mem_req || exp_mr) begin
        chk("mem_req", 64'(bus.o_mem_req), 64'(exp_mr));
        if (exp_mr) begin
          chk("mem_addr", 64'(bus.o_mem_addr), 64'(cur.addr));
          chk("mem_wdata", 64'(bus.o_mem_wdata), 64'(cur.wdata));
          chk("mem_we_bmask", 64'({bus.o_mem_we, bus.o_mem_bmask}), 64'({cur.we, cur.bm}));
        end
      end
      if (bus.o_core_rvalid || (exp_rv && !side)) begin
        chk("core_rvalid", 64'(bus.o_core_rvalid), 64'(exp_rv && !side));
        if (exp_rv && !side) chk("core_rdata", 64'(bus.o_core_rdata), 64'(cur.rdata));
      end
      if (bus.o_dbg_rvalid || (exp_rv && side)) begin
        chk("dbg_rvalid", 64'(bus.o_dbg_rvalid), 64'(exp_rv && side));
        if (exp_rv && side) chk("dbg_rdata", 64'(bus.o_dbg_rdata), 64'(cur.rdata));
      end
      if (exp_rv) chk("mem_addr_hold", 64'(bus.o_mem_addr), 64'(cur.addr));
      if (bus.i_core_req || bus.o_core_stall)
        chk("core_stall", 64'(bus.o_core_stall), 64'(bus.i_core_req && !(exp_rv && !side)));
      if (exp_rv) busy = 1'b0;
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.i_core_req = 1'b0; bus.i_core_we = 1'b0; bus.i_core_addr = '0; bus.i_core_wdata = '0; bus.i_core_bmask = '0;
    bus.i_dbg_req = 1'b0; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0; bus.i_dbg_bmask = '0;
    bus.i_mem_rdata = '0;
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h14] = 32'h1111_1111;
    mem[32'h18] = 32'h2222_2222;
    mem[32'h1C] = 32'h3333_3333;
    mem[32'h20] = 32'h4444_4444;
    mem[32'h24] = 32'h5555_5555;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_gnt", 64'({bus.o_core_gnt, bus.o_dbg_gnt}), 0);
    chk("rst_rvalid", 64'({bus.o_core_rvalid, bus.o_dbg_rvalid}), 0);
    chk("rst_mem_req", 64'(bus.o_mem_req), 0);
    chk("rst_rdata", {bus.o_core_rdata, bus.o_dbg_rdata}, 0);
    chk("rst_mem_payload", {bus.o_mem_addr, bus.o_mem_wdata}, 0);
    chk("rst_mem_we_bm", 64'({bus.o_mem_we, bus.o_mem_bmask}), 0);
    single(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF);
    single(1, 1'b1, 32'h100, 32'h1234_5678, 4'hF, 32'h0);
    single(1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h1234_5678);
    single(0, 1'b1, 32'h100, 32'hAAAA_BBBB, 4'h3, 32'h0);
    single(1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h1234_BBBB);
`ifdef ARB_STARVE_GUARD_EN
    ord_q.push_back(0); ord_q.push_back(0); ord_q.push_back(1);
    ord_q.push_back(0); ord_q.push_back(0); ord_q.push_back(1);
`else
    ord_q.push_back(0); ord_q.push_back(0); ord_q.push_back(0);
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(1);
`endif
    fork
      begin
        drive(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF);
        drive(0, 1'b0, 32'h14, 32'h0, 4'hF, 32'h1111_1111);
        drive(0, 1'b0, 32'h18, 32'h0, 4'hF, 32'h2222_2222);
        drive(0, 1'b0, 32'h1C, 32'h0, 4'hF, 32'h3333_3333);
        bus.i_core_req = 1'b0;
      end
      begin
        drive(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h4444_4444);
        drive(1, 1'b0, 32'h24, 32'h0, 4'hF, 32'h5555_5555);
        bus.i_dbg_req = 1'b0;
      end
    join
    fork
      single(0, 1'b0, 32'h14, 32'h0, 4'hF, 32'h1111_1111);
      begin
        repeat (2) @(posedge clk);
        #1;
        single(1, 1'b0, 32'h18, 32'h0, 4'hF, 32'h2222_2222);
      end
    join
    ord_q.push_back(0);
    core_q.push_back('{1'b0, 32'h1C, 32'h0, 4'hF, 32'h3333_3333});
    bus.i_core_req = 1'b1; bus.i_core_we = 1'b0; bus.i_core_addr = 32'h1C; bus.i_core_wdata = '0; bus.i_core_bmask = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_core_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_rvalid", 64'({bus.o_core_rvalid, bus.o_dbg_rvalid}), 0);
    chk("midrst_mem_req", 64'(bus.o_mem_req), 0);
    chk("midrst_rdata", {bus.o_core_rdata, bus.o_dbg_rdata}, 0);
    chk("midrst_mem_addr", 64'(bus.o_mem_addr), 0);
    chk("midrst_mem_we_bm", 64'({bus.o_mem_we, bus.o_mem_bmask}), 0);
    repeat (8) @(posedge clk);
    #1;
    single(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF);
    repeat (4) @(posedge clk);
    #1;
    chk("core_q_left", 64'(core_q.size()), 0);
    chk("dbg_q_left", 64'(dbg_q.size()), 0);
    chk("ord_q_left", 64'(ord_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
